sal_timing_reg: RTL and testbench

SAL_TIMING_REG -- requirements
Module: sal_timing_reg

---
 rtl/sal_timing_reg_if.sv | 34 +++
 rtl/sal_timing_reg.sv | 230 +++++++++++++++++++++++
 tb/tb_sal_timing_reg.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sal_timing_reg_if.sv
// ---------------------------------------------------------------------------
// sal_timing_reg_if
// APB bus bundle for the DRAM timing register block.
//
// Signals:
//   psel     master->slave  select
//   penable  master->slave  access phase
//   pwrite   master->slave  1 = write, 0 = read
//   paddr    master->slave  byte address (8 bits, low two bits ignored)
//   pwdata   master->slave  write data
//   pready   slave->master  transfer complete
//   prdata   slave->master  read data
//   pslverr  slave->master  transfer error
// ---------------------------------------------------------------------------
interface sal_timing_reg_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/sal_timing_reg.sv
// ---------------------------------------------------------------------------
// sal_timing_reg
// Double-buffered DRAM timing configuration registers. Software edits the
// shadow copies over APB and then writes COMMIT. The block asks the scheduler
// to quiesce, and once the scheduler acknowledges it copies all four shadows
// into the active images in a single cycle, so the timing interface never
// sees a half-updated set. If the scheduler never acknowledges, the commit
// is abandoned and a sticky timeout flag is raised.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   apb          APB slave (psel/penable/pwrite/paddr/pwdata/pready/prdata/pslverr)
//   quiesce_req  request to the scheduler to stop issuing commands
//   quiesce_ack  scheduler reports idle
//   t_cfg0..2    active TIMING0/1/2 images
//   t_lat        active LAT image
//
// Register map (byte addresses):
//   0x00-0x0C  shadow TIMING0/1/2/LAT (RW)
//   0x10       CTRL, bit0 COMMIT (write 1, reads 0)
//   0x14       STATUS: [0] busy, [1] tmo_err (write 1 to clear), [15:8] commit_cnt
//   0x20-0x2C  active TIMING0/1/2/LAT (RO)
// ---------------------------------------------------------------------------
module sal_timing_reg #(
   parameter logic [31:0] RST_T0  = 32'h110A0A13,
   parameter logic [31:0] RST_T1  = 32'h40030745,
   parameter logic [31:0] RST_T2  = 32'h03040301,
   parameter logic [31:0] RST_LAT = 32'h00000604,
   parameter int unsigned QTMO    = 255
) (
   input  logic             clk,
   input  logic             rst,
   sal_timing_reg_if.slave  apb,
   output logic             quiesce_req,
   input  logic             quiesce_ack,
   output logic [31:0]      t_cfg0,
   output logic [31:0]      t_cfg1,
   output logic [31:0]      t_cfg2,
   output logic [31:0]      t_lat
);

   // Only dfi_wren_lat [3:0] and dfi_rden_lat [11:8] exist in LAT.
   localparam logic [31:0] LAT_MASK = 32'h00000F0F;

   // The wait counter only has to reach QTMO-1: the REQ cycle in which it
   // holds that value is the last one spent waiting.
   localparam int CW = (QTMO < 2) ? 1 : $clog2(QTMO);
   localparam logic [CW-1:0] TMO_LAST = (QTMO == 0) ? '0 : CW'(QTMO - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      APPLY,
      REL
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] wait_cnt;
   logic          apply_en;
   logic          tmo_hit;

   logic [31:0]   sh_t0, sh_t1, sh_t2, sh_lat;
   logic [31:0]   act_t0, act_t1, act_t2, act_lat;
   logic          tmo_err;
   logic [7:0]    commit_cnt;
   logic          busy;
   logic [31:0]   status_val;

   logic [7:0]    addr;
   logic          access;
   logic          mapped;
   logic          read_only;
   logic          cfg_space;
   logic          err;
   logic          wr_ok;
   logic [31:0]   rd_val;

   // Word-aligned address; masking keeps the ignored low bits out of decode.
   assign addr      = apb.paddr & 8'hFC;
   assign access    = apb.psel & apb.penable;
   assign busy      = (state != IDLE);
   assign status_val = {16'h0000, commit_cnt, 6'b000000, tmo_err, busy};

   // Address decode and read mux. Shadows and CTRL form the configuration
   // space that is frozen while a commit is in progress; the active images
   // are read-only; everything else is unmapped.
   always_comb begin
      rd_val    = '0;
      mapped    = 1'b1;
      read_only = 1'b0;
      cfg_space = 1'b0;
      case (addr)
         8'h00: begin rd_val = sh_t0;  cfg_space = 1'b1; end
         8'h04: begin rd_val = sh_t1;  cfg_space = 1'b1; end
         8'h08: begin rd_val = sh_t2;  cfg_space = 1'b1; end
         8'h0C: begin rd_val = sh_lat; cfg_space = 1'b1; end
         8'h10: begin rd_val = '0;     cfg_space = 1'b1; end
         8'h14: rd_val = status_val;
         8'h20: begin rd_val = act_t0;  read_only = 1'b1; end
         8'h24: begin rd_val = act_t1;  read_only = 1'b1; end
         8'h28: begin rd_val = act_t2;  read_only = 1'b1; end
         8'h2C: begin rd_val = act_lat; read_only = 1'b1; end
         default: mapped = 1'b0;
      endcase
   end

   // Error rules: an unmapped address fails either direction; writes also
   // fail on read-only registers and on configuration space while busy.
   assign err   = ~mapped | (apb.pwrite & (read_only | (cfg_space & busy)));
   assign wr_ok = access & apb.pwrite & ~err;

   assign apb.pready  = 1'b1;
   assign apb.pslverr = access & err;
   assign apb.prdata  = (access & ~apb.pwrite & ~err) ? rd_val : '0;

   // State register for the commit handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Commit sequencing. IDLE waits for COMMIT, REQ waits for the scheduler to
   // go quiet (or gives up), APPLY is the single copy cycle, and REL holds
   // off the next commit until the scheduler has seen the request drop.
   always_comb begin
      state_nxt = state;
      apply_en  = 1'b0;
      tmo_hit   = 1'b0;
      case (state)
         IDLE: begin
            if (wr_ok && (addr == 8'h10) && apb.pwdata[0]) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (quiesce_ack) begin
               state_nxt = APPLY;
            end else if (wait_cnt == TMO_LAST) begin
               state_nxt = IDLE;
               tmo_hit   = 1'b1;
            end
         end
         APPLY: begin
            apply_en  = 1'b1;
            state_nxt = REL;
         end
         REL: begin
            if (!quiesce_ack) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign quiesce_req = (state == REQ) || (state == APPLY);

   // Wait counter restarts every time REQ is entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state == REQ) begin
         wait_cnt <= wait_cnt + 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end

   // Shadow registers, writable only while idle (enforced through err).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_t0  <= RST_T0;
         sh_t1  <= RST_T1;
         sh_t2  <= RST_T2;
         sh_lat <= RST_LAT;
      end else if (wr_ok) begin
         case (addr)
            8'h00:   sh_t0  <= apb.pwdata;
            8'h04:   sh_t1  <= apb.pwdata;
            8'h08:   sh_t2  <= apb.pwdata;
            8'h0C:   sh_lat <= apb.pwdata & LAT_MASK;
            default: ;
         endcase
      end
   end

   // Active images move together in APPLY and nowhere else.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_t0  <= RST_T0;
         act_t1  <= RST_T1;
         act_t2  <= RST_T2;
         act_lat <= RST_LAT;
      end else if (apply_en) begin
         act_t0  <= sh_t0;
         act_t1  <= sh_t1;
         act_t2  <= sh_t2;
         act_lat <= sh_lat;
      end
   end

   // Status bookkeeping. A timeout in the same cycle as a clear wins, so a
   // fresh failure is never lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_err    <= 1'b0;
         commit_cnt <= '0;
      end else begin
         if (tmo_hit) begin
            tmo_err <= 1'b1;
         end else if (wr_ok && (addr == 8'h14) && apb.pwdata[1]) begin
            tmo_err <= 1'b0;
         end
         if (apply_en) begin
            commit_cnt <= commit_cnt + 8'd1;
         end
      end
   end

   assign t_cfg0 = act_t0;
   assign t_cfg1 = act_t1;
   assign t_cfg2 = act_t2;
   assign t_lat  = act_lat;

endmodule

// File: tb/tb_sal_timing_reg.sv
// ---------------------------------------------------------------------------
// tb_sal_timing_reg
// Directed bench for sal_timing_reg. Every APB transfer queues its expected
// response; a monitor compares whenever an access phase completes. Timing
// interface outputs and quiesce_req are checked directly at chosen cycles.
// ---------------------------------------------------------------------------
module tb_sal_timing_reg;

   typedef struct packed {
      logic        chk_rd;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        quiesce_req;
   logic        quiesce_ack;
   logic [31:0] t_cfg0, t_cfg1, t_cfg2, t_lat;

   int          tests_run;
   int          tests_failed;

   exp_t        exp_q[$];
   string       name_q[$];
   exp_t        mon_exp;
   string       mon_name;

   sal_timing_reg_if apb_bus ();

   sal_timing_reg dut (
      .clk         (clk),
      .rst         (rst),
      .apb         (apb_bus),
      .quiesce_req (quiesce_req),
      .quiesce_ack (quiesce_ack),
      .t_cfg0      (t_cfg0),
      .t_cfg1      (t_cfg1),
      .t_cfg2      (t_cfg2),
      .t_lat       (t_lat)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something stalls the stimulus.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // One complete APB transfer; the expected response is queued when the
   // access phase starts.
   task automatic applyStimulus(input logic wr, input logic [7:0] addr,
                                input logic [31:0] data, input logic [31:0] exp_rd,
                                input logic exp_err, input string name);
      exp_t e;
      @(posedge clk); #1;
      apb_bus.psel    = 1'b1;
      apb_bus.penable = 1'b0;
      apb_bus.pwrite  = wr;
      apb_bus.paddr   = addr;
      apb_bus.pwdata  = data;
      @(posedge clk); #1;
      e.chk_rd = ~wr;
      e.rdata  = exp_rd;
      e.err    = exp_err;
      exp_q.push_back(e);
      name_q.push_back(name);
      apb_bus.penable = 1'b1;
      @(posedge clk); #1;
      apb_bus.psel    = 1'b0;
      apb_bus.penable = 1'b0;
      apb_bus.pwrite  = 1'b0;
   endtask

   // Direct comparison of a DUT output against a bench constant.
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: sample each completed access phase on the falling
   // edge and compare against the oldest queued expectation.
   always @(negedge clk) begin
      if (apb_bus.psel && apb_bus.penable && apb_bus.pready) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL unexpected_access: addr %02h with empty queue", apb_bus.paddr);
         end else begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            if ((apb_bus.pslverr !== mon_exp.err) ||
                (mon_exp.chk_rd && (apb_bus.prdata !== mon_exp.rdata))) begin
               tests_failed++;
               $display("[TB] FAIL %s: got err=%0b data=%08h expected err=%0b data=%08h",
                        mon_name, apb_bus.pslverr, apb_bus.prdata, mon_exp.err, mon_exp.rdata);
            end
         end
      end
   end

   // Directed scenario.
   initial begin
      tests_run       = 0;
      tests_failed    = 0;
      rst             = 1'b1;
      quiesce_ack     = 1'b0;
      apb_bus.psel    = 1'b0;
      apb_bus.penable = 1'b0;
      apb_bus.pwrite  = 1'b0;
      apb_bus.paddr   = 8'h00;
      apb_bus.pwdata  = 32'h0;

      // Reset values.
      #12;
      checkOutput("rst_qreq",  {31'h0, quiesce_req}, 32'h0);
      checkOutput("rst_cfg0",  t_cfg0, 32'h110A0A13);
      checkOutput("rst_cfg1",  t_cfg1, 32'h40030745);
      checkOutput("rst_cfg2",  t_cfg2, 32'h03040301);
      checkOutput("rst_lat",   t_lat,  32'h00000604);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(1'b0, 8'h20, 32'h0, 32'h110A0A13, 1'b0, "rd_act_t0_rst");
      applyStimulus(1'b0, 8'h2C, 32'h0, 32'h00000604, 1'b0, "rd_act_lat_rst");
      applyStimulus(1'b0, 8'h14, 32'h0, 32'h00000000, 1'b0, "rd_status_rst");
      applyStimulus(1'b0, 8'h01, 32'h0, 32'h110A0A13, 1'b0, "rd_sh_t0_lowbits");

      // Shadow writes, LAT masking, bad addresses, read-only writes.
      applyStimulus(1'b1, 8'h00, 32'h22151426, 32'h0, 1'b0, "wr_sh_t0");
      applyStimulus(1'b1, 8'h0C, 32'hFFFFF7F5, 32'h0, 1'b0, "wr_sh_lat");
      applyStimulus(1'b0, 8'h0C, 32'h0, 32'h00000705, 1'b0, "rd_sh_lat_masked");
      applyStimulus(1'b0, 8'h10, 32'h0, 32'h00000000, 1'b0, "rd_ctrl_zero");
      applyStimulus(1'b1, 8'h30, 32'h12345678, 32'h0, 1'b1, "wr_unmapped");
      applyStimulus(1'b0, 8'h30, 32'h0, 32'h00000000, 1'b1, "rd_unmapped");
      applyStimulus(1'b1, 8'h20, 32'hCAFEF00D, 32'h0, 1'b1, "wr_ro_active");
      applyStimulus(1'b0, 8'h20, 32'h0, 32'h110A0A13, 1'b0, "rd_act_t0_after_ro");

      // Commit with no acknowledge: times out after exactly QTMO REQ cycles.
      applyStimulus(1'b1, 8'h10, 32'h1, 32'h0, 1'b0, "commit_tmo");
      checkOutput("tmo_qreq_start", {31'h0, quiesce_req}, 32'h1);
      repeat (254) @(posedge clk);
      #1;
      checkOutput("tmo_qreq_last", {31'h0, quiesce_req}, 32'h1);
      @(posedge clk); #1;
      checkOutput("tmo_qreq_drop", {31'h0, quiesce_req}, 32'h0);
      checkOutput("tmo_cfg0_kept", t_cfg0, 32'h110A0A13);
      applyStimulus(1'b0, 8'h14, 32'h0, 32'h00000002, 1'b0, "rd_status_tmo");
      applyStimulus(1'b1, 8'h14, 32'h0, 32'h0, 1'b0, "wr_status_zero");
      applyStimulus(1'b0, 8'h14, 32'h0, 32'h00000002, 1'b0, "rd_status_sticky");
      applyStimulus(1'b1, 8'h14, 32'hFFFFFFFF, 32'h0, 1'b0, "wr_status_clear");
      applyStimulus(1'b0, 8'h14, 32'h0, 32'h00000000, 1'b0, "rd_status_cleared");

      // Successful commit with a blocked write while waiting.
      applyStimulus(1'b1, 8'h10, 32'h1, 32'h0, 1'b0, "commit_ok");
      checkOutput("ok_qreq", {31'h0, quiesce_req}, 32'h1);
      applyStimulus(1'b1, 8'h04, 32'hDEADBEEF, 32'h0, 1'b1, "wr_sh_t1_in_req");
      applyStimulus(1'b0, 8'h14, 32'h0, 32'h00000001, 1'b0, "rd_status_req");
      quiesce_ack = 1'b1;
      @(posedge clk); #1;
      checkOutput("apply_qreq", {31'h0, quiesce_req}, 32'h1);
      checkOutput("apply_cfg0_old", t_cfg0, 32'h110A0A13);
      @(posedge clk); #1;
      checkOutput("rel_qreq", {31'h0, quiesce_req}, 32'h0);
      checkOutput("rel_cfg0_new", t_cfg0, 32'h22151426);
      checkOutput("rel_lat_new", t_lat, 32'h00000705);
      applyStimulus(1'b0, 8'h14, 32'h0, 32'h00000101, 1'b0, "rd_status_rel");
      quiesce_ack = 1'b0;
      @(posedge clk); #1;
      applyStimulus(1'b0, 8'h14, 32'h0, 32'h00000100, 1'b0, "rd_status_done");
      applyStimulus(1'b0, 8'h04, 32'h0, 32'h40030745, 1'b0, "rd_sh_t1_unchanged");
      applyStimulus(1'b0, 8'h20, 32'h0, 32'h22151426, 1'b0, "rd_act_t0_new");

      // Acknowledge while idle must not start anything.
      quiesce_ack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("idle_ack_qreq", {31'h0, quiesce_req}, 32'h0);
      applyStimulus(1'b0, 8'h14, 32'h0, 32'h00000100, 1'b0, "rd_status_idle_ack");
      quiesce_ack = 1'b0;

      // Reset in the middle of a commit.
      applyStimulus(1'b1, 8'h08, 32'h0A0B0C0D, 32'h0, 1'b0, "wr_sh_t2");
      applyStimulus(1'b1, 8'h10, 32'h1, 32'h0, 1'b0, "commit_abort");
      checkOutput("abort_qreq_before", {31'h0, quiesce_req}, 32'h1);
      rst = 1'b1;
      #1;
      checkOutput("abort_qreq", {31'h0, quiesce_req}, 32'h0);
      checkOutput("abort_cfg0", t_cfg0, 32'h110A0A13);
      checkOutput("abort_cfg1", t_cfg1, 32'h40030745);
      checkOutput("abort_cfg2", t_cfg2, 32'h03040301);
      checkOutput("abort_lat",  t_lat,  32'h00000604);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 8'h14, 32'h0, 32'h00000000, 1'b0, "rd_status_abort");
      applyStimulus(1'b0, 8'h08, 32'h0, 32'h03040301, 1'b0, "rd_sh_t2_abort");
      applyStimulus(1'b0, 8'h0C, 32'h0, 32'h00000604, 1'b0, "rd_sh_lat_abort");

      // 256 commits wrap the commit counter.
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b1, 8'h10, 32'h1, 32'h0, 1'b0, "commit_loop");
         quiesce_ack = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         quiesce_ack = 1'b0;
         @(posedge clk); #1;
         if (i == 254) begin
            applyStimulus(1'b0, 8'h14, 32'h0, 32'h0000FF00, 1'b0, "rd_status_255");
         end
      end
      applyStimulus(1'b0, 8'h14, 32'h0, 32'h00000000, 1'b0, "rd_status_wrap");

      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
